// File: rtl/regfile_scoreboard_if.sv
// Issue, writeback and debug bundle for the scoreboarded register file.
// The master drives requests; the slave returns grants and read data.
interface regfile_scoreboard_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             issue_valid;
  logic             issue_use1;
  logic             issue_use2;
  logic [AW-1:0]    issue_src1;
  logic [AW-1:0]    issue_src2;
  logic             issue_wr;
  logic [AW-1:0]    issue_dst;
  logic             issue_ready;
  logic [WIDTH-1:0] rd1_data;
  logic [WIDTH-1:0] rd2_data;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             busy;
  logic             wb_err;
  logic [15:0]      stall_count;
  logic [AW-1:0]    dbg_sel;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output issue_valid, issue_use1, issue_use2,
    output issue_src1, issue_src2,
    output issue_wr, issue_dst,
    output wb_en, wb_addr, wb_data, dbg_sel,
    input  issue_ready, rd1_data, rd2_data,
    input  busy, wb_err, stall_count, dbg_data
  );

  modport slave (
    input  issue_valid, issue_use1, issue_use2,
    input  issue_src1, issue_src2,
    input  issue_wr, issue_dst,
    input  wb_en, wb_addr, wb_data, dbg_sel,
    output issue_ready, rd1_data, rd2_data,
    output busy, wb_err, stall_count, dbg_data
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass and per-register pending-write
// scoreboard producing the RAW/WAW issue stall decision.
module regfile_scoreboard #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 3,
  parameter int ZERO_REG     = 0
) (
  input logic clock,
  input logic reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [WIDTH-1:0] mem_q  [DEPTH];
  logic [WIDTH-1:0] mem_d  [DEPTH];
  logic [CW-1:0]    pend_q [DEPTH];
  logic [CW-1:0]    pend_d [DEPTH];
  logic             err_q, err_d;
  logic [15:0]      stall_q, stall_d;

  logic [DEPTH-1:0] zr, hit, blk, full, inc, dec;
  logic             ready, fire, busy_c;

  always_comb begin
    zr     = '0;
    hit    = '0;
    blk    = '0;
    full   = '0;
    inc    = '0;
    dec    = '0;
    busy_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      zr[i]   = (ZERO_REG != 0) && (i == 0);
      hit[i]  = bus.wb_en && (bus.wb_addr == AW'(i));
      blk[i]  = !zr[i] && ((pend_q[i] > CW'(1)) ||
                ((pend_q[i] == CW'(1)) && !hit[i]));
      full[i] = !zr[i] && !hit[i] &&
                (pend_q[i] == CW'(MAX_INFLIGHT));
      busy_c  = busy_c | (pend_q[i] != '0);
    end
    ready = !(bus.issue_use1 && blk[bus.issue_src1]) &&
            !(bus.issue_use2 && blk[bus.issue_src2]) &&
            !(bus.issue_wr && full[bus.issue_dst]);
    fire  = bus.issue_valid && ready && bus.issue_wr;
    for (int i = 0; i < DEPTH; i++) begin
      inc[i] = fire && (bus.issue_dst == AW'(i)) && !zr[i];
      dec[i] = hit[i] && (pend_q[i] != '0) && !zr[i];
    end
  end

  always_comb begin
    mem_d   = mem_q;
    pend_d  = pend_q;
    err_d   = err_q;
    stall_d = stall_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (inc[i] && !dec[i])
        pend_d[i] = pend_q[i] + CW'(1);
      else if (dec[i] && !inc[i])
        pend_d[i] = pend_q[i] - CW'(1);
    end
    // data lands even when the counter was already empty
    if (bus.wb_en && !zr[bus.wb_addr]) begin
      mem_d[bus.wb_addr] = bus.wb_data;
      if (pend_q[bus.wb_addr] == '0)
        err_d = 1'b1;
    end
    if (bus.issue_valid && !ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      pend_q  <= '{default: '0};
      err_q   <= 1'b0;
      stall_q <= 16'd0;
    end else begin
      mem_q   <= mem_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  logic zr1, zr2;
  assign zr1 = (ZERO_REG != 0) && (bus.issue_src1 == '0);
  assign zr2 = (ZERO_REG != 0) && (bus.issue_src2 == '0);

  assign bus.rd1_data = zr1 ? '0 :
    hit[bus.issue_src1] ? bus.wb_data : mem_q[bus.issue_src1];
  assign bus.rd2_data = zr2 ? '0 :
    hit[bus.issue_src2] ? bus.wb_data : mem_q[bus.issue_src2];

  assign bus.issue_ready = ready;
  assign bus.busy        = busy_c;
  assign bus.wb_err      = err_q;
  assign bus.stall_count = stall_q;
  assign bus.dbg_data    = mem_q[bus.dbg_sel];
endmodule
